// File: rtl/fsoc_pio_pkg.sv
// Shared definitions for the base_sys GPIO responder:
// bus data width and the register index map.
package fsoc_pio_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    REG_DATA = 3'd0,
    REG_OUT  = 3'd1,
    REG_SET  = 3'd2,
    REG_CLR  = 3'd3,
    REG_MASK = 3'd4,
    REG_EDGE = 3'd5
  } reg_idx_e;

endpackage

// File: rtl/pio_debounce.sv
// Single-bit input conditioner: 2-FF synchroniser then debouncer.
// Ports: clk, reset_n, pin (async raw), stable (debounced), toggle (accept pulse).
module pio_debounce #(
  parameter int DEB_CYC = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable,
  output logic toggle
);

  localparam int CW = $clog2(DEB_CYC);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          diff;

  assign diff = s2 != stable;

  // Combinational so edge capture can set in the same cycle stable flips.
  assign toggle = diff && (cnt == CW'(DEB_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (!diff) begin
        cnt <= '0;
      end else if (toggle) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/avalon_pio_responder.sv
// Avalon-MM GPIO responder: debounced edge-captured inputs, LED register.
// Ports: clk, reset_n, avs_* bus (1-cycle read latency), irq, pio_in, pio_out.
module avalon_pio_responder
  import fsoc_pio_pkg::*;
#(
  parameter int               IN_W    = 2,
  parameter int               OUT_W   = 8,
  parameter int               DEB_CYC = 50000,
  parameter logic [OUT_W-1:0] OUT_RST = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              irq,
  input  logic [IN_W-1:0]   pio_in,
  output logic [OUT_W-1:0]  pio_out
);

  logic [IN_W-1:0]   stable;
  logic [IN_W-1:0]   toggle;
  logic [OUT_W-1:0]  out_reg;
  logic [IN_W-1:0]   irq_mask;
  logic [IN_W-1:0]   edge_cap;
  logic [IN_W-1:0]   w1c;
  logic [DATA_W-1:0] rd_mux;
  logic [OUT_W-1:0]  wd_out;
  logic [IN_W-1:0]   wd_in;
  logic              unused;

  assign wd_out  = avs_writedata[OUT_W-1:0];
  assign wd_in   = avs_writedata[IN_W-1:0];
  assign unused  = ^avs_writedata;
  assign pio_out = out_reg;

  for (genvar i = 0; i < IN_W; i++) begin : g_deb
    pio_debounce #(
      .DEB_CYC(DEB_CYC)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (pio_in[i]),
      .stable (stable[i]),
      .toggle (toggle[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      REG_DATA: rd_mux[IN_W-1:0]  = stable;
      REG_OUT:  rd_mux[OUT_W-1:0] = out_reg;
      REG_MASK: rd_mux[IN_W-1:0]  = irq_mask;
      REG_EDGE: rd_mux[IN_W-1:0]  = edge_cap;
      default:  rd_mux = '0;
    endcase
  end

  assign w1c = (avs_write && avs_address == REG_EDGE)
             ? wd_in : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= OUT_RST;
      irq_mask <= '0;
    end else if (avs_write) begin
      case (avs_address)
        REG_OUT:  out_reg  <= wd_out;
        REG_SET:  out_reg  <= out_reg | wd_out;
        REG_CLR:  out_reg  <= out_reg & ~wd_out;
        REG_MASK: irq_mask <= wd_in;
        default:  ;
      endcase
    end
  end

  // A new edge outranks a simultaneous clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~w1c) | toggle;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdata      <= avs_read ? rd_mux : '0;
      avs_readdatavalid <= avs_read;
    end
  end

endmodule

// File: tb/tb_avalon_pio_responder.sv
// Randomised + directed bench for avalon_pio_responder (DEB_CYC=4).
module tb_avalon_pio_responder;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        irq;
  logic [1:0]  pio_in = '0;
  logic [7:0]  pio_out;

  int n_tests = 0;
  int n_fail = 0;

  avalon_pio_responder #(
    .IN_W   (2),
    .OUT_W  (8),
    .DEB_CYC(DEB),
    .OUT_RST(8'h00)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_address      (avs_address),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .irq              (irq),
    .pio_in           (pio_in),
    .pio_out          (pio_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Reference model: register file as plain variables,
  // debounce as a rule over the pin sample history.
  logic [7:0]  m_out;
  logic [1:0]  m_mask;
  logic [1:0]  m_ecap;
  logic [1:0]  m_stab;
  logic        m_irq;
  logic        m_rdv;
  logic [31:0] m_rdata;
  logic [1:0]  hist[$];

  function automatic logic [31:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0:    return {30'd0, m_stab};
      3'd1:    return {24'd0, m_out};
      3'd4:    return {30'd0, m_mask};
      3'd5:    return {30'd0, m_ecap};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [1:0] t;
    logic [1:0] newcap;
    logic       all_diff;
    if (!reset_n) begin
      m_out = 8'h00; m_mask = '0; m_ecap = '0;
      m_stab = '0; m_irq = 1'b0; m_rdv = 1'b0;
      m_rdata = '0;
      hist.delete();
      for (int i = 0; i < 8; i++) hist.push_back(2'b00);
    end else begin
      m_rdv   = avs_read;
      m_rdata = avs_read ? reg_val(avs_address) : 32'd0;
      m_irq   = |(m_ecap & m_mask);
      // hist[0] is this edge's pin; the debouncer sees
      // the pin two edges late.
      hist.push_front(pio_in);
      while (hist.size() > 8) void'(hist.pop_back());
      t = '0;
      for (int b = 0; b < 2; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++)
          if (hist[2+j][b] == m_stab[b]) all_diff = 1'b0;
        t[b] = all_diff;
      end
      newcap = m_ecap;
      if (avs_write) begin
        case (avs_address)
          3'd1: m_out = avs_writedata[7:0];
          3'd2: m_out = m_out | avs_writedata[7:0];
          3'd3: m_out = m_out & ~avs_writedata[7:0];
          3'd4: m_mask = avs_writedata[1:0];
          3'd5: newcap = newcap & ~avs_writedata[1:0];
          default: ;
        endcase
      end
      m_ecap = newcap | t;
      m_stab = m_stab ^ t;
    end
  end

  always @(negedge clk) begin
    chk("rdv", {31'd0, avs_readdatavalid}, {31'd0, m_rdv});
    chk("rdata", avs_readdata, m_rdata);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("pio_out", {24'd0, pio_out}, {24'd0, m_out});
  end

  // One bus cycle: drive, then advance to just after the next negedge.
  task automatic cyc(input logic rd, input logic wr,
                     input logic [2:0] a, input logic [31:0] d);
    avs_read = rd;
    avs_write = wr;
    avs_address = a;
    avs_writedata = d;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_out", {24'd0, pio_out}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);

    // Reset values read back to back.
    cyc(1, 0, 3'd0, 0);
    chk("rst_v0", {31'd0, avs_readdatavalid}, 32'd1);
    cyc(1, 0, 3'd1, 0);
    cyc(1, 0, 3'd4, 0);
    cyc(1, 0, 3'd5, 0);
    chk("rst_edge", avs_readdata, 32'h0);
    idle(1);
    chk("rst_vend", {31'd0, avs_readdatavalid}, 32'd0);

    // Output register and aliases.
    cyc(0, 1, 3'd1, 32'hFFFF_FFA5);
    chk("out_a5", {24'd0, pio_out}, 32'hA5);
    cyc(0, 1, 3'd2, 32'h0F);
    chk("out_af", {24'd0, pio_out}, 32'hAF);
    cyc(0, 1, 3'd3, 32'h81);
    chk("out_2e", {24'd0, pio_out}, 32'h2E);
    cyc(1, 0, 3'd1, 0);
    chk("rd_out", avs_readdata, 32'h2E);
    cyc(0, 1, 3'd7, 32'hFF);
    chk("wr7", {24'd0, pio_out}, 32'h2E);
    cyc(1, 0, 3'd2, 0);
    chk("rd_set", avs_readdata, 32'h0);

    // Short glitch is rejected.
    pio_in[0] = 1'b1;
    idle(3);
    pio_in[0] = 1'b0;
    idle(8);
    cyc(1, 0, 3'd0, 0);
    chk("glitch_d", avs_readdata, 32'h0);
    cyc(1, 0, 3'd5, 0);
    chk("glitch_e", avs_readdata, 32'h0);

    // Held level accepted 2+DEB cycles later.
    pio_in[0] = 1'b1;
    idle(5);
    cyc(1, 0, 3'd0, 0);
    chk("deb_e6", avs_readdata, 32'h0);
    cyc(1, 0, 3'd0, 0);
    chk("deb_e7", avs_readdata, 32'h1);
    cyc(1, 0, 3'd5, 0);
    chk("edge1", avs_readdata, 32'h1);

    // IRQ path.
    cyc(0, 1, 3'd5, 32'h3);
    cyc(0, 1, 3'd4, 32'h2);
    pio_in[1] = 1'b1;
    idle(8);
    chk("irq_on", {31'd0, irq}, 32'd1);
    cyc(1, 0, 3'd5, 0);
    chk("edge2", avs_readdata, 32'h2);
    cyc(0, 1, 3'd5, 32'h2);
    idle(2);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    pio_in[1] = 1'b0;
    idle(8);
    chk("irq_on2", {31'd0, irq}, 32'd1);
    cyc(0, 1, 3'd4, 32'h0);
    idle(1);
    chk("irq_mask0", {31'd0, irq}, 32'd0);

    // W1C colliding with a new edge on the same bit.
    cyc(0, 1, 3'd5, 32'h3);
    pio_in[0] = 1'b0;
    idle(5);
    cyc(0, 1, 3'd5, 32'h1);
    cyc(1, 0, 3'd5, 0);
    chk("coll", avs_readdata, 32'h1);

    // Read and write of OUT together.
    cyc(1, 1, 3'd1, 32'h3C);
    chk("rw_old", avs_readdata, 32'h2E);
    chk("rw_new", {24'd0, pio_out}, 32'h3C);

    // Reset during a pending read.
    avs_read = 1'b1;
    avs_address = 3'd1;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_rdv", {31'd0, avs_readdatavalid}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    chk("rst2_out", {24'd0, pio_out}, 32'h0);
    cyc(1, 0, 3'd1, 0);
    cyc(1, 0, 3'd4, 0);
    cyc(1, 0, 3'd5, 0);
    cyc(1, 0, 3'd0, 0);
    idle(1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0)
        pio_in = 2'($urandom_range(3));
      cyc(($urandom_range(4) < 2), ($urandom_range(4) < 2),
          3'($urandom_range(7)), $urandom);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
